// File: rtl/inert_pkg.sv
// inert_pkg: shared state encoding and SPI command helper for the inertial read sequencer.
package inert_pkg;
  typedef enum logic [1:0] {PWRUP, INIT, IDLE, RD} state_e;
  function automatic logic [15:0] spi_rd_cmd(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction
endpackage

// File: rtl/inert_seq_rd_sync2.sv
// inert_seq_rd_sync2: two-flop synchroniser for the asynchronous sensor data-ready line.
module inert_seq_rd_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff_q <= '0;
    else ff_q <= {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/inert_seq_rd.sv
// inert_seq_rd: power-up init writer and frame reader driving an external 16-bit SPI master.
module inert_seq_rd
  import inert_pkg::*;
#(
  parameter int                     NUM_CH    = 5,
  parameter logic [6:0]             BASE_ADDR = 7'h22,
  parameter int                     NUM_INIT  = 4,
  parameter logic [16*NUM_INIT-1:0] INIT_CMDS = {16'h1460, 16'h1162, 16'h1062, 16'h0D02},
  parameter int                     PWRUP_CYC = 65535,
  parameter int                     TMO_CYC   = 4095
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 INT,
  input  logic                 mode,
  input  logic                 trig,
  input  logic                 reinit,
  input  logic                 clr_err,
  output logic                 spi_wrt,
  output logic [15:0]          spi_cmd,
  input  logic                 spi_done,
  input  logic [15:0]          spi_rd,
  output logic [NUM_CH*16-1:0] data,
  output logic                 vld,
  output logic                 init_done,
  output logic                 busy,
  output logic                 err_tmo,
  output logic                 ovr
);
  localparam int KW = $clog2(2*NUM_CH+1);
  localparam int IW = $clog2(NUM_INIT+1);
  localparam int PW = $clog2(PWRUP_CYC+1);
  localparam int TW = $clog2(TMO_CYC+1);
  localparam logic [KW-1:0] K_LAST = KW'(2*NUM_CH-1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_INIT-1);
  localparam logic [PW-1:0] PW_END = PW'(PWRUP_CYC);
  localparam logic [TW-1:0] TW_END = TW'(TMO_CYC-1);

  state_e                 state_q;
  logic [PW-1:0]          pwr_q;
  logic [TW-1:0]          tmo_q;
  logic [KW-1:0]          k_q;
  logic [IW-1:0]          idx_q;
  logic [NUM_CH*16-9:0]   shadow_q;
  logic [NUM_CH*16-1:0]   data_q;
  logic [15:0]            spi_cmd_q;
  logic                   spi_wrt_q, vld_q, init_done_q, err_tmo_q, ovr_q, int_prev_q;
  logic                   int_s;
  logic [KW-1:0]          k_n;
  logic [IW-1:0]          idx_n;
  logic                   unused_hi;

  inert_seq_rd_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d_i(INT), .q_o(int_s));

  assign k_n       = k_q + 1'b1;
  assign idx_n     = idx_q + 1'b1;
  assign unused_hi = ^spi_rd[15:8];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= PWRUP;
      pwr_q       <= '0;
      tmo_q       <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      data_q      <= '0;
      spi_cmd_q   <= '0;
      spi_wrt_q   <= 1'b0;
      vld_q       <= 1'b0;
      init_done_q <= 1'b0;
      err_tmo_q   <= 1'b0;
      ovr_q       <= 1'b0;
      int_prev_q  <= 1'b0;
    end else begin
      spi_wrt_q  <= 1'b0;
      vld_q      <= 1'b0;
      int_prev_q <= int_s;
      if (clr_err) begin
        err_tmo_q <= 1'b0;
        ovr_q     <= 1'b0;
      end
      // later writes of 1 override the clear above, so a fresh error survives clr_err
      if (state_q == RD && int_s && !int_prev_q) ovr_q <= 1'b1;
      if (reinit) begin
        state_q     <= PWRUP;
        init_done_q <= 1'b0;
        pwr_q       <= '0;
        tmo_q       <= '0;
      end else
        case (state_q)
          PWRUP:
            if (pwr_q == PW_END) begin
              spi_wrt_q <= 1'b1;
              spi_cmd_q <= INIT_CMDS[15:0];
              idx_q     <= '0;
              tmo_q     <= '0;
              state_q   <= INIT;
            end else pwr_q <= pwr_q + 1'b1;
          INIT:
            if (spi_done) begin
              if (idx_q == I_LAST) begin
                init_done_q <= 1'b1;
                state_q     <= IDLE;
              end else begin
                idx_q     <= idx_n;
                spi_cmd_q <= INIT_CMDS[16*idx_n +: 16];
                spi_wrt_q <= 1'b1;
                tmo_q     <= '0;
              end
            end else if (tmo_q == TW_END) begin
              err_tmo_q <= 1'b1;
              pwr_q     <= '0;
              state_q   <= PWRUP;
            end else tmo_q <= tmo_q + 1'b1;
          IDLE:
            if (mode ? trig : int_s) begin
              spi_wrt_q <= 1'b1;
              spi_cmd_q <= spi_rd_cmd(BASE_ADDR);
              k_q       <= '0;
              tmo_q     <= '0;
              state_q   <= RD;
            end
          RD:
            if (spi_done) begin
              if (k_q == K_LAST) begin
                data_q  <= {spi_rd[7:0], shadow_q};
                vld_q   <= 1'b1;
                state_q <= IDLE;
              end else begin
                shadow_q[8*k_q +: 8] <= spi_rd[7:0];
                k_q       <= k_n;
                spi_cmd_q <= spi_rd_cmd(BASE_ADDR + 7'(k_n));
                spi_wrt_q <= 1'b1;
                tmo_q     <= '0;
              end
            end else if (tmo_q == TW_END) begin
              err_tmo_q <= 1'b1;
              state_q   <= IDLE;
            end else tmo_q <= tmo_q + 1'b1;
          default: state_q <= PWRUP;
        endcase
    end

  assign spi_wrt   = spi_wrt_q;
  assign spi_cmd   = spi_cmd_q;
  assign data      = data_q;
  assign vld       = vld_q;
  assign init_done = init_done_q;
  assign busy      = state_q != IDLE;
  assign err_tmo   = err_tmo_q;
  assign ovr       = ovr_q;
endmodule

// File: tb/tb_inert_seq_rd.sv
// tb_inert_seq_rd: SPI slave model plus frame scoreboard checking inert_seq_rd every cycle.
module tb_inert_seq_rd;
  localparam int NCH = 5;
  localparam int T   = 40;

  logic clk = 1'b0, rst_n = 1'b0, INT = 1'b0, mode = 1'b0, trig = 1'b0;
  logic reinit = 1'b0, clr_err = 1'b0, spi_done = 1'b0;
  logic [15:0] spi_rd = '0;
  logic spi_wrt, vld, init_done, busy, err_tmo, ovr;
  logic [15:0] spi_cmd;
  logic [NCH*16-1:0] data;

  int n_chk = 0, n_fail = 0, n_vld = 0;
  int mk = 0, hold_k = -1, cnt = 0, cyc = 0, drops = 0;
  bit run = 0, txn = 0, held = 0, pend = 0;
  logic [15:0] cur_cmd = '0, last_rd_cmd = '0;
  logic [7:0] fbase = '0;
  logic [7:0] mbytes [2*NCH];
  logic [NCH*16-1:0] exp_data = '0, frame = '0;
  logic [15:0] init_q [$];

  always #5 clk = ~clk;

  inert_seq_rd #(.NUM_CH(NCH), .PWRUP_CYC(16), .TMO_CYC(200)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .mode(mode), .trig(trig), .reinit(reinit),
    .clr_err(clr_err), .spi_wrt(spi_wrt), .spi_cmd(spi_cmd), .spi_done(spi_done),
    .spi_rd(spi_rd), .data(data), .vld(vld), .init_done(init_done), .busy(busy),
    .err_tmo(err_tmo), .ovr(ovr)
  );

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SPI slave model and scoreboard: published data may only move to a fully delivered frame
  always begin
    @(negedge clk);
    if (run) begin
      if (pend) exp_data = frame;
      chk("vld", vld, pend);
      chk("data", data, exp_data);
      if (txn && !spi_wrt) chk("cmd_stable", spi_cmd, cur_cmd);
    end
    if (vld) n_vld++;
    pend = 0;
    spi_done = 1'b0;
    if (spi_wrt) begin
      txn = 1; cnt = 0; cur_cmd = spi_cmd; held = 0;
      if (spi_cmd[15]) begin
        chk("rd_cmd", spi_cmd, {1'b1, 7'(7'h22 + mk), 8'h00});
        last_rd_cmd = spi_cmd;
        held = (mk == hold_k);
        mk = held ? 0 : mk + 1;
      end else init_q.push_back(spi_cmd);
    end else if (txn) begin
      cnt++;
      if (!held && cnt == T) begin
        int k;
        logic [7:0] b;
        k = int'(cur_cmd[14:8]) - 'h22;
        b = fbase + 8'(k) + 8'd1;
        spi_done = 1'b1;
        spi_rd = {8'hEE, b};
        txn = 0;
        if (cur_cmd[15] && k >= 0 && k < 2*NCH) begin
          mbytes[k] = b;
          if (k == 2*NCH-1) begin
            for (int i = 0; i < 2*NCH; i++) frame[8*i +: 8] = mbytes[i];
            pend = 1;
            mk = 0;
          end
        end
      end
    end
  end

  task automatic pulse_trig();
    trig = 1'b1; @(negedge clk); trig = 1'b0;
  endtask

  task automatic wait_cmd(input logic [15:0] c, input int bound, input string name);
    int i;
    for (i = 0; i < bound && !(spi_wrt && spi_cmd == c); i++) @(negedge clk);
    chk(name, spi_wrt && spi_cmd == c, 1);
  endtask

  task automatic wait_vld(input string name);
    int i;
    for (i = 0; i < 1500 && !vld; i++) @(negedge clk);
    chk(name, vld, 1);
  endtask

  task automatic check_init(input string name);
    chk({name, "_cnt"}, init_q.size(), 4);
    if (init_q.size() == 4) begin
      chk({name, "_0"}, init_q[0], 16'h0D02);
      chk({name, "_1"}, init_q[1], 16'h1062);
      chk({name, "_2"}, init_q[2], 16'h1162);
      chk({name, "_3"}, init_q[3], 16'h1460);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wrt", spi_wrt, 0);
    chk("rst_cmd", spi_cmd, 0);
    chk("rst_data", data, 0);
    chk("rst_vld", vld, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_flags", {err_tmo, ovr}, 0);
    run = 1;
    rst_n = 1'b1;
    // 1: power-up wait and init table
    cyc = 0;
    while (!spi_wrt && cyc < 100) begin @(negedge clk); cyc++; end
    chk("pwrup_wait", cyc >= 16 && cyc <= 18, 1);
    for (int i = 0; i < 1000 && !init_done; i++) @(negedge clk);
    chk("init_done", init_done, 1);
    chk("idle_busy", busy, 0);
    check_init("init");
    // 2: continuous mode, INT-triggered frame
    mode = 1'b0; fbase = 8'h00; INT = 1'b1;
    wait_cmd(16'hA200, 50, "int_start");
    INT = 1'b0;
    wait_vld("int_vld");
    chk("int_ch0", data[15:0], 16'h0201);
    chk("int_ch4", data[79:64], 16'h0A09);
    chk("last_cmd", last_rd_cmd, 16'hAB00);
    chk("no_ovr", ovr, 0);
    repeat (60) @(negedge clk);
    chk("int_one_vld", n_vld, 1);
    chk("int_idle", busy, 0);
    // 3: one-shot mode, second trig mid-frame is dropped
    mode = 1'b1; fbase = 8'h10;
    pulse_trig();
    wait_cmd(16'hA200, 10, "trig_start");
    repeat (100) @(negedge clk);
    pulse_trig();
    wait_vld("trig_vld");
    chk("trig_ch0", data[15:0], 16'h1211);
    repeat (60) @(negedge clk);
    chk("trig_one_vld", n_vld, 2);
    chk("trig_idle", busy, 0);
    // 4: withheld spi_done on read k=3
    fbase = 8'h20; hold_k = 3;
    pulse_trig();
    wait_cmd(16'hA500, 500, "tmo_k3");
    cyc = 0;
    while (!err_tmo && cyc < 400) begin @(negedge clk); cyc++; end
    hold_k = -1;
    chk("tmo_time", cyc >= 198 && cyc <= 202, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_data", data[15:0], 16'h1211);
    chk("tmo_no_vld", n_vld, 2);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0; @(negedge clk);
    chk("tmo_clr", err_tmo, 0);
    // 5: INT re-rises mid-frame
    mode = 1'b0; fbase = 8'h30; INT = 1'b1;
    wait_cmd(16'hA200, 50, "ovr_start");
    INT = 1'b0;
    repeat (100) @(negedge clk);
    INT = 1'b1;
    for (int i = 0; i < 10 && !ovr; i++) @(negedge clk);
    chk("ovr_set", ovr, 1);
    INT = 1'b0;
    wait_vld("ovr_vld");
    chk("ovr_ch0", data[15:0], 16'h3231);
    chk("ovr_sticky", ovr, 1);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0; @(negedge clk);
    chk("ovr_clr", ovr, 0);
    repeat (20) @(negedge clk);
    // 6: reinit during read k=5
    mode = 1'b1; fbase = 8'h40;
    pulse_trig();
    wait_cmd(16'hA700, 500, "re_k5");
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0; mk = 0; init_q.delete();
    chk("re_no_wrt", spi_wrt, 0);
    chk("re_busy", busy, 1);
    chk("re_init_clr", init_done, 0);
    drops = 0;
    for (int i = 0; i < 1000 && !init_done; i++) begin
      if (!busy) drops++;
      @(negedge clk);
    end
    chk("re_done", init_done, 1);
    chk("re_busy_held", drops, 0);
    check_init("reinit");
    chk("re_data", data[15:0], 16'h3231);
    chk("re_vld_cnt", n_vld, 3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
